cordic_result_uart_tx: RTL and testbench



---
 rtl/cordic_result_uart_tx_pkg.sv | 47 ++++
 rtl/cordic_result_uart_tx_if.sv | 12 +
 rtl/cordic_result_uart_tx_uart_tx_byte.sv | 105 ++++++++++
 rtl/cordic_result_uart_tx.sv | 92 +++++++++
 tb/tb_cordic_result_uart_tx.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_result_uart_tx_pkg.sv
// Shared constants, state encoding and frame-character helpers for the CORDIC result UART reporter.
package cordic_result_uart_tx_pkg;

    localparam logic [7:0] ASCII_X     = 8'h58;
    localparam logic [7:0] ASCII_Y     = 8'h59;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int FRAME_LEN  = 31;
    localparam int CHAR_IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START_BIT,
        ST_DATA,
        ST_STOP_BIT
    } tx_state_e;

    // Non-decimal nibbles are flagged as '?' rather than silently mapped.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (ASCII_ZERO + {4'h0, d}) : ASCII_QMARK;
    endfunction

    // "X=" + 12 x digits + ' ' + "Y=" + 12 y digits + CR LF, most significant digit first.
    function automatic logic [7:0] frame_char(input logic [CHAR_IDX_W-1:0] idx,
                                              input logic [47:0] x,
                                              input logic [47:0] y);
        int i;
        logic [7:0] ch;
        i = int'(idx);
        if (i == 0)       ch = ASCII_X;
        else if (i == 1)  ch = ASCII_EQ;
        else if (i <= 13) ch = digit_to_ascii(x[4*(13-i) +: 4]);
        else if (i == 14) ch = ASCII_SP;
        else if (i == 15) ch = ASCII_Y;
        else if (i == 16) ch = ASCII_EQ;
        else if (i <= 28) ch = digit_to_ascii(y[4*(28-i) +: 4]);
        else if (i == 29) ch = ASCII_CR;
        else              ch = ASCII_LF;
        return ch;
    endfunction

endpackage

// File: rtl/cordic_result_uart_tx_if.sv
// Request/status bundle between the CORDIC control logic and the result UART reporter.
interface cordic_result_uart_tx_if;
    logic        start;
    logic [47:0] x_bcd;
    logic [47:0] y_bcd;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (output start, x_bcd, y_bcd, input tx, busy, done);
    modport slave  (input start, x_bcd, y_bcd, output tx, busy, done);
endinterface

// File: rtl/cordic_result_uart_tx_uart_tx_byte.sv
// 8N1 byte serializer; byte_ready is high in IDLE and in the last cycle of a stop bit so
// consecutive bytes can be chained with no idle gap.
module uart_tx_byte
    import cordic_result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       tx,
    output logic       byte_ready
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end    = (cnt_q == CNT_LAST);
    assign byte_ready = (state_q == ST_IDLE) || ((state_q == ST_STOP_BIT) && bit_end);
    assign tx         = tx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (byte_valid) begin
                    state_d = ST_START_BIT;
                    shreg_d = byte_data;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            ST_START_BIT: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP_BIT;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP_BIT: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_valid) begin
                        state_d = ST_START_BIT;
                        shreg_d = byte_data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/cordic_result_uart_tx.sv
// Captures packed-BCD X/Y results on start and reports them as one 31-character ASCII line
// over an 8N1 UART, with busy/done status for the control logic.
module cordic_result_uart_tx
    import cordic_result_uart_tx_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input logic                    clk,
    input logic                    reset,
    cordic_result_uart_tx_if.slave bus
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be >= 2");
    end

    localparam logic [CHAR_IDX_W-1:0] LAST_CHAR = CHAR_IDX_W'(FRAME_LEN - 1);

    logic [47:0]           x_q, x_d;
    logic [47:0]           y_q, y_d;
    logic [CHAR_IDX_W-1:0] char_idx_q, char_idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            char_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            char_idx_q <= char_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // char_idx_q tracks the character currently on the line; the next one is offered
    // in the final stop-bit cycle so the serializer chains it without a gap.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        char_idx_d = char_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_valid = 1'b0;
        byte_data  = ASCII_X;
        if (!busy_q) begin
            if (bus.start) begin
                x_d        = bus.x_bcd;
                y_d        = bus.y_bcd;
                busy_d     = 1'b1;
                char_idx_d = '0;
                byte_valid = 1'b1;
                byte_data  = frame_char('0, bus.x_bcd, bus.y_bcd);
            end
        end else if (byte_ready) begin
            if (char_idx_q == LAST_CHAR) begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                char_idx_d = '0;
            end else begin
                char_idx_d = char_idx_q + 1'b1;
                byte_valid = 1'b1;
                byte_data  = frame_char(char_idx_q + 1'b1, x_q, y_q);
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .tx        (bus.tx),
        .byte_ready(byte_ready)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_cordic_result_uart_tx.sv
// Scoreboarded bench: expected frame bytes are queued when start is driven and a UART
// receiver process pops and compares each decoded byte.
module tb_cordic_result_uart_tx;

    localparam int CPB       = 10;
    localparam int FRAME_CYC = 31 * 10 * CPB;

    logic clk;
    logic reset;
    int   tests_run;
    int   fails;
    int   gen;
    logic [7:0] exp_q[$];

    cordic_result_uart_tx_if bus ();

    cordic_result_uart_tx #(
        .CLK_HZ(1000),
        .BAUD  (100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : {4'h3, n};
    endfunction

    function automatic void push_frame(input logic [47:0] x, input logic [47:0] y);
        exp_q.push_back(8'h58);
        exp_q.push_back(8'h3D);
        for (int i = 11; i >= 0; i--) exp_q.push_back(nib2asc(x[i*4 +: 4]));
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h59);
        exp_q.push_back(8'h3D);
        for (int i = 11; i >= 0; i--) exp_q.push_back(nib2asc(y[i*4 +: 4]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // UART receiver: first low sample on a falling clock edge marks a start bit; each
    // following bit is sampled near its middle. Bytes cut short by a reset are dropped.
    initial begin : rx_monitor
        int g;
        logic [7:0] b;
        logic [7:0] e;
        logic stop_v;
        forever begin
            @(negedge clk);
            if (!reset && bus.tx === 1'b0) begin
                g = gen;
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = bus.tx;
                end
                repeat (CPB) @(negedge clk);
                stop_v = bus.tx;
                if (g == gen) begin
                    tests_run++;
                    if (stop_v !== 1'b1) begin
                        fails++;
                        $display("FAIL rx stop bit: got %b want 1", stop_v);
                    end
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL rx unexpected byte: got %h want none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            fails++;
                            $display("FAIL rx byte: got %h want %h", b, e);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.x_bcd = 48'h123456789012;
        bus.y_bcd = 48'h000000000001;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                fails++;
                $display("FAIL reset outputs: got tx=%b busy=%b done=%b want 1 0 0",
                         bus.tx, bus.busy, bus.done);
            end
        end
        reset = 1'b0;
        bus.start = 1'b0;
        begin
            int bad = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
            end
            tests_run++;
            if (bad != 0) begin
                fails++;
                $display("FAIL idle after reset: got %0d active cycles want 0", bad);
            end
        end
    endtask

    // Sends one frame; poke_at > 0 pulses start with new x data at that cycle of the frame.
    task automatic run_frame(input string name, input logic [47:0] x, input logic [47:0] y,
                             input int poke_at);
        int cyc = 0;
        int busy_bad = 0;
        int extra = 0;
        bit seen = 0;
        @(negedge clk);
        bus.x_bcd = x;
        bus.y_bcd = y;
        bus.start = 1'b1;
        push_frame(x, y);
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.tx !== 1'b0) begin
            fails++;
            $display("FAIL %s accept: got busy=%b tx=%b want 1 0", name, bus.busy, bus.tx);
        end
        while (!seen && cyc < FRAME_CYC + 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == poke_at) begin
                bus.x_bcd = 48'h999999999999;
                bus.start = 1'b1;
            end else if (cyc == poke_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) seen = 1;
            else if (bus.busy !== 1'b1) busy_bad++;
        end
        tests_run++;
        if (!seen || cyc != FRAME_CYC) begin
            fails++;
            $display("FAIL %s done latency: got %0d (seen=%0d) want %0d", name, cyc, seen, FRAME_CYC);
        end
        tests_run++;
        if (busy_bad != 0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s busy window: got %0d gaps, busy=%b at done want 0 gaps, 0",
                     name, busy_bad, bus.busy);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy !== 1'b0) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            fails++;
            $display("FAIL %s after done: got %0d extra done/busy cycles want 0", name, extra);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s bytes left: got %0d unreceived want 0", name, exp_q.size());
        end
    endtask

    task automatic test_normal_frame();
        run_frame("normal", 48'h000000012345, 48'h000000000707, 0);
    endtask

    task automatic test_ignored_start();
        run_frame("ignored_start", 48'h000000012345, 48'h000000000707, 1200);
    endtask

    task automatic test_invalid_nibble();
        run_frame("invalid_nibble", 48'h00000000A00F, 48'h000000000000, 0);
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        @(negedge clk);
        bus.x_bcd = 48'h111111111111;
        bus.y_bcd = 48'h222222222222;
        bus.start = 1'b1;
        push_frame(bus.x_bcd, bus.y_bcd);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        gen++;
        exp_q.delete();
        tests_run++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid abort: got tx=%b busy=%b done=%b want 1 0 0",
                     bus.tx, bus.busy, bus.done);
        end
        reset = 1'b0;
        for (int c = 0; c < FRAME_CYC + 100; c++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid quiet: got %0d active cycles want 0", bad);
        end
        run_frame("after_reset", 48'h876543210987, 48'h000000000042, 0);
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        bit seen = 0;
        @(negedge clk);
        bus.x_bcd = 48'h314159265358;
        bus.y_bcd = 48'h271828182845;
        bus.start = 1'b1;
        push_frame(bus.x_bcd, bus.y_bcd);
        @(posedge clk); #1;
        bus.x_bcd = 48'h000000000099;
        while (!seen && cyc < FRAME_CYC + 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen || cyc != FRAME_CYC) begin
            fails++;
            $display("FAIL b2b first done: got %0d (seen=%0d) want %0d", cyc, seen, FRAME_CYC);
        end
        push_frame(bus.x_bcd, bus.y_bcd);
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests_run++;
        if (bus.tx !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL b2b restart: got tx=%b busy=%b done=%b want 0 1 0",
                     bus.tx, bus.busy, bus.done);
        end
        cyc = 0;
        seen = 0;
        while (!seen && cyc < FRAME_CYC + 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen || cyc != FRAME_CYC) begin
            fails++;
            $display("FAIL b2b second done: got %0d (seen=%0d) want %0d", cyc, seen, FRAME_CYC);
        end
        repeat (20) @(posedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL b2b bytes left: got %0d unreceived want 0", exp_q.size());
        end
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run = 0;
        fails     = 0;
        gen       = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.x_bcd = '0;
        bus.y_bcd = '0;
        test_reset();
        test_normal_frame();
        test_ignored_start();
        test_invalid_nibble();
        test_reset_mid_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
